// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART debug command responder.
// UART_CMD_CHECKSUM_EN adds a trailing XOR byte to frames and read responses.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

`ifdef UART_CMD_CHECKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif

    // Frame geometry: address and data fields are four bytes, LSB first.
    localparam int ADDR_BYTES = 4;
    localparam int DATA_BYTES = 4;
    localparam int RD_RSP_LEN = 4 + CHK_BYTES;

    // Response serializer holds up to five bytes.
    localparam int RSP_W = 40;
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_MEM,
        ST_RESP,
        ST_WAIT_DONE
`ifdef UART_CMD_CHECKSUM_EN
        , ST_CHK
`endif
    } state_t;

    function automatic logic [7:0] xor_bytes(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

endpackage

// File: rtl/uart_cmd_resp_ser.sv
// Response shift register: presents one byte at a time to uart_tx and
// advances on each tx_done while more response bytes remain.
module uart_cmd_resp_ser
    import uart_cmd_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic [RSP_W-1:0] i_data,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_send,
    input  logic             i_ack,
    input  logic             tx_active,
    output logic             tx_dv,
    output logic [7:0]       tx_byte,
    output logic             o_more
);

    logic [RSP_W-1:0] r_shift;
    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_count <= i_count;
        end else if (i_ack) begin
            r_shift <= {8'h00, r_shift[RSP_W-1:8]};
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Strobe is combinational so it appears the cycle the FSM enters RESP.
    assign tx_dv   = i_send && !tx_active;
    assign tx_byte = r_shift[7:0];
    assign o_more  = (r_count > CNT_W'(1));

endmodule

// File: rtl/uart_cmd_responder.sv
// Host debug responder: parses 'W'/'R' frames from uart_rx, runs one 32-bit bus
// transaction, answers through uart_tx. Optional macro: UART_CMD_CHECKSUM_EN.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_250_000,
    parameter int TO_W           = 21
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err_drop
);

    state_t          r_state;
    logic [1:0]      r_idx;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_err_drop;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]      r_xor;
`endif

    logic             w_is_cmd;
    logic             w_collect;
    logic             w_timeout;
    logic             w_last_idx;
    logic             w_busy;
    logic             w_send;
    logic             w_ack;
    logic             w_more;
    logic             w_load;
    logic [RSP_W-1:0] w_load_data;
    logic [CNT_W-1:0] w_load_cnt;

    assign w_is_cmd   = (rx_byte == CMD_WR) || (rx_byte == CMD_RD);
    assign w_last_idx = (r_idx == 2'(ADDR_BYTES - 1));
    assign w_busy     = (r_state == ST_MEM) || (r_state == ST_RESP) || (r_state == ST_WAIT_DONE);
    assign w_send     = (r_state == ST_RESP);
    assign w_ack      = (r_state == ST_WAIT_DONE) && tx_done;

    // The checksum wait also times out so a lost trailing byte cannot hang the FSM.
`ifdef UART_CMD_CHECKSUM_EN
    assign w_collect = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_CHK);
`else
    assign w_collect = (r_state == ST_ADDR) || (r_state == ST_DATA);
`endif
    assign w_timeout = w_collect && !rx_dv && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_load      = 1'b0;
        w_load_data = '0;
        w_load_cnt  = '0;
        if (r_state == ST_IDLE && rx_dv && !w_is_cmd) begin
            w_load      = 1'b1;
            w_load_data = {32'h0, RSP_NAK};
            w_load_cnt  = CNT_W'(1);
        end else if (r_state == ST_MEM && mem_ready) begin
            w_load = 1'b1;
            if (r_mem_we) begin
                w_load_data = {32'h0, RSP_ACK};
                w_load_cnt  = CNT_W'(1);
            end else begin
`ifdef UART_CMD_CHECKSUM_EN
                w_load_data = {xor_bytes(mem_rdata), mem_rdata};
`else
                w_load_data = {8'h00, mem_rdata};
`endif
                w_load_cnt  = CNT_W'(RD_RSP_LEN);
            end
        end
`ifdef UART_CMD_CHECKSUM_EN
        else if (r_state == ST_CHK && rx_dv && rx_byte != r_xor) begin
            w_load      = 1'b1;
            w_load_data = {32'h0, RSP_NAK};
            w_load_cnt  = CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (rx_dv) begin
                    if (w_is_cmd) begin
                        r_mem_we <= (rx_byte == CMD_WR);
                        r_idx    <= '0;
                        r_state  <= ST_ADDR;
                    end else begin
                        r_state  <= ST_RESP;
                    end
                end
                ST_ADDR: if (rx_dv) begin
                    r_addr[{r_idx, 3'b000} +: 8] <= rx_byte;
                    r_idx <= r_idx + 2'd1;
                    if (w_last_idx) begin
                        if (r_mem_we) begin
                            r_state <= ST_DATA;
                        end else begin
`ifdef UART_CMD_CHECKSUM_EN
                            r_state   <= ST_CHK;
`else
                            r_state   <= ST_MEM;
                            r_mem_req <= 1'b1;
`endif
                        end
                    end
                end else if (w_timeout) begin
                    r_state <= ST_IDLE;
                end
                ST_DATA: if (rx_dv) begin
                    r_wdata[{r_idx, 3'b000} +: 8] <= rx_byte;
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'(DATA_BYTES - 1)) begin
`ifdef UART_CMD_CHECKSUM_EN
                        r_state   <= ST_CHK;
`else
                        r_state   <= ST_MEM;
                        r_mem_req <= 1'b1;
`endif
                    end
                end else if (w_timeout) begin
                    r_state <= ST_IDLE;
                end
`ifdef UART_CMD_CHECKSUM_EN
                ST_CHK: if (rx_dv) begin
                    if (rx_byte == r_xor) begin
                        r_state   <= ST_MEM;
                        r_mem_req <= 1'b1;
                    end else begin
                        r_state   <= ST_RESP;
                    end
                end else if (w_timeout) begin
                    r_state <= ST_IDLE;
                end
`endif
                ST_MEM: if (mem_ready) begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_RESP;
                end
                ST_RESP: if (tx_dv) begin
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: if (tx_done) begin
                    r_state <= w_more ? ST_RESP : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_CMD_CHECKSUM_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_xor <= '0;
        end else if (r_state == ST_IDLE && rx_dv) begin
            r_xor <= rx_byte;
        end else if (w_collect && rx_dv) begin
            r_xor <= r_xor ^ rx_byte;
        end
    end
`endif

    // A received byte always beats a simultaneous timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= '0;
        end else if (!w_collect || rx_dv || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_drop <= 1'b0;
        end else if (rx_dv && w_busy) begin
            r_err_drop <= 1'b1;
        end
    end

    uart_cmd_resp_ser u_ser (
        .clk       (clk),
        .resetn    (resetn),
        .i_load    (w_load),
        .i_data    (w_load_data),
        .i_count   (w_load_cnt),
        .i_send    (w_send),
        .i_ack     (w_ack),
        .tx_active (tx_active),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .o_more    (w_more)
    );

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign err_drop  = r_err_drop;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with a behavioural uart_tx and bus stub.
module tb_uart_cmd_responder;
    import uart_cmd_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err_drop;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          req_cnt = 0;
    int          n_overlap = 0;
    logic        req_prev = 1'b0;
    bit          tx_model_busy = 1'b0;
    logic [7:0]  tx_log[$];

    uart_cmd_responder #(.TIMEOUT_CYCLES(50), .TO_W(21)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err_drop  (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // uart_tx stand-in: busy for four cycles per byte, then one tx_done pulse.
    initial begin
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_dv === 1'b1) begin
                tx_model_busy = 1'b1;
                @(posedge clk); #1 tx_active = 1'b1;
                repeat (4) @(posedge clk);
                #1 tx_active = 1'b0; tx_done = 1'b1;
                @(posedge clk); #1 tx_done = 1'b0;
                tx_model_busy = 1'b0;
            end
        end
    end

    // Monitor: log every tx_dv byte and count mem_req rising edges.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_dv === 1'b1) begin
                tx_log.push_back(tx_byte);
                if (tx_active) n_overlap++;
            end
            if (mem_req === 1'b1 && req_prev !== 1'b1) req_cnt++;
            req_prev = mem_req;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_dv = 1'b1; rx_byte = b;
        @(posedge clk); #1 rx_dv = 1'b0; rx_byte = 8'h00;
    endtask

    // Sends a frame, appending the XOR byte in checksum builds.
    task automatic send_frame(input byte_q_t fr, input int gap);
        logic [7:0] x;
        x = 8'h00;
        foreach (fr[i]) begin
            if (i != 0) repeat (gap) @(posedge clk);
            send_byte(fr[i]);
            x = x ^ fr[i];
        end
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    function automatic byte_q_t rd_rsp(input logic [31:0] d);
        byte_q_t q;
        q = '{d[7:0], d[15:8], d[23:16], d[31:24]};
`ifdef UART_CMD_CHECKSUM_EN
        q.push_back(d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]);
`endif
        return q;
    endfunction

    task automatic mem_complete(input string tag, input logic [31:0] rd, input int delay,
                                input logic [7:0] first_byte);
        repeat (delay) begin
            @(posedge clk); #1;
            check({tag, "_req_hold"}, mem_req, 1);
        end
        mem_rdata = rd; mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0; mem_rdata = 32'h0;
        check({tag, "_req_drop"}, mem_req, 0);
        check({tag, "_first_tx_dv"}, tx_dv, 1);
        check({tag, "_first_tx_byte"}, tx_byte, first_byte);
    endtask

    task automatic expect_resp(input string tag, input byte_q_t exp);
        int c;
        c = 0;
        while ((tx_log.size() < exp.size() || tx_model_busy) && c < 1000) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_nbytes"}, tx_log.size(), exp.size());
        foreach (exp[i]) begin
            if (i < tx_log.size()) check($sformatf("%s_byte%0d", tag, i), tx_log[i], exp[i]);
        end
        check({tag, "_no_overlap"}, n_overlap, 0);
        check({tag, "_idle"}, dut.r_state, ST_IDLE);
    endtask

    initial begin
        int req_base;
        int c;
        resetn = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
        mem_rdata = 32'h0; mem_ready = 1'b0;

        repeat (3) @(posedge clk); #1;
        check("rst_tx_dv", tx_dv, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_err_drop", err_drop, 0);
        @(negedge clk) resetn = 1'b1;

        // Write frame: ACK after a single transaction.
        tx_log.delete(); req_base = req_cnt;
        send_frame('{8'h57, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 0);
        check("wr_req_latency", mem_req, 1);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 32'h8000_0010);
        check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_complete("wr", 32'h0, 0, 8'h06);
        expect_resp("wr", '{8'h06});
        check("wr_req_count", req_cnt - req_base, 1);

        // Read frame with a three-cycle bus stall.
        tx_log.delete(); req_base = req_cnt;
        send_frame('{8'h52, 8'h00, 8'h01, 8'h00, 8'h00}, 0);
        check("rd_req_latency", mem_req, 1);
        check("rd_we", mem_we, 0);
        check("rd_addr", mem_addr, 32'h0000_0100);
        mem_complete("rd", 32'h1234_5678, 3, 8'h78);
        expect_resp("rd", rd_rsp(32'h1234_5678));
        check("rd_req_count", req_cnt - req_base, 1);

        // Unknown command byte: single NAK, no bus activity.
        tx_log.delete(); req_base = req_cnt;
        send_byte(8'hAA);
        check("nak_tx_dv", tx_dv, 1);
        check("nak_tx_byte", tx_byte, 8'h15);
        expect_resp("nak", '{8'h15});
        check("nak_no_req", req_cnt - req_base, 0);

        // Partial frame then silence past the timeout.
        tx_log.delete(); req_base = req_cnt;
        send_byte(8'h57); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
        repeat (60) @(posedge clk); #1;
        check("to_idle", dut.r_state, ST_IDLE);
        check("to_no_req", req_cnt - req_base, 0);
        check("to_no_tx", tx_log.size(), 0);

        // Following read with 40-cycle gaps stays under the timeout.
        send_frame('{8'h52, 8'h04, 8'h00, 8'h00, 8'h00}, 40);
        check("gap_req", mem_req, 1);
        check("gap_addr", mem_addr, 32'h0000_0004);
        mem_complete("gap", 32'hAABB_CCDD, 1, 8'hDD);
        expect_resp("gap", rd_rsp(32'hAABB_CCDD));

        // Byte arriving during WAIT_DONE is dropped and flagged.
        tx_log.delete(); req_base = req_cnt;
        check("drop_flag_clear", err_drop, 0);
        send_frame('{8'h52, 8'h20, 8'h00, 8'h00, 8'h00}, 0);
        mem_complete("drop", 32'hCAFE_F00D, 0, 8'h0D);
        c = 0;
        while (!tx_active && c < 20) begin @(posedge clk); #1; c++; end
        check("drop_tx_busy", tx_active, 1);
        send_byte(8'h52);
        check("drop_flag_set", err_drop, 1);
        expect_resp("drop", rd_rsp(32'hCAFE_F00D));
        check("drop_req_count", req_cnt - req_base, 1);
        check("drop_flag_sticky", err_drop, 1);

        // Asynchronous reset while a write is pending on the bus.
        send_frame('{8'h57, 8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04}, 0);
        check("rstmid_req_before", mem_req, 1);
        #2 resetn = 1'b0;
        #1;
        check("rstmid_req", mem_req, 0);
        check("rstmid_tx_dv", tx_dv, 0);
        check("rstmid_we", mem_we, 0);
        check("rstmid_addr", mem_addr, 32'h0);
        check("rstmid_wdata", mem_wdata, 32'h0);
        check("rstmid_err_drop", err_drop, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;

`ifdef UART_CMD_CHECKSUM_EN
        // Wrong trailing checksum: NAK and no transaction.
        tx_log.delete(); req_base = req_cnt;
        send_byte(8'h57);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        send_byte(8'h00);
        check("chk_no_req_now", mem_req, 0);
        check("chk_nak_byte", tx_byte, 8'h15);
        expect_resp("chk", '{8'h15});
        check("chk_req_count", req_cnt - req_base, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Host-side debug responder. Consumes bytes from the uart_rx instance and parses fixed-length command frames.
- Issues single 32-bit memory-mapped read/write transactions on a simple request/ready bus into the CPU address space.
- Returns response bytes through the uart_tx instance.
- Sits in top between urx/utx and the memory-mapped I/O decode, beside riscv_multi.

Parameters:
- TIMEOUT_CYCLES, 1_250_000, idle cycles between frame bytes before the partial frame is discarded (~100 ms at 12 MHz).
- TO_W, 21, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rx_dv  in  1  one-cycle strobe, rx_byte valid (from uart_rx o_Rx_DV)
- rx_byte  in  8  received byte
- tx_dv  out  1  one-cycle strobe to uart_tx i_Tx_DV
- tx_byte  out  8  byte to send; stable from tx_dv until tx_done
- tx_active  in  1  uart_tx busy
- tx_done  in  1  one-cycle pulse, byte fully sent
- mem_req  out  1  transaction request, held until mem_ready
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  32  byte address, little-endian assembled
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1
- mem_ready  in  1  transaction accepted/completed this cycle
- err_drop  out  1  sticky: a byte arrived while busy and was dropped

Behaviour:
- Reset (async, resetn=0):
  - Outputs: tx_dv=0, tx_byte=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err_drop=0.
  - Internal: state=IDLE, counters=0.
- Frame format:
  - Write: 0x57 'W', A0..A3, D0..D3. Bytes are LSB first.
  - Read: 0x52 'R', A0..A3.
- Responses:
  - Write: 0x06 (ACK).
  - Read: D0..D3, LSB first.
  - Unknown command byte: 0x15 (NAK).
- FSM states: IDLE, ADDR, DATA, MEM, RESP, WAIT_DONE.
  - IDLE, rx_dv:
    - 0x57 or 0x52: latch mem_we, go to ADDR with byte index=0.
    - Any other value: load NAK, go to RESP.
  - ADDR: each rx_dv shifts rx_byte into mem_addr[8*idx +: 8]. After idx=3, go to DATA (write) or MEM (read).
  - DATA: same fill of mem_wdata. After idx=3, go to MEM.
  - MEM: mem_req=1 until the cycle mem_ready=1, then mem_req=0 the next cycle.
    - Read: capture mem_rdata into the response shift register; 4 bytes to send.
    - Write: response is ACK; 1 byte to send.
    - Go to RESP.
  - RESP: when tx_active=0, assert tx_dv for exactly one cycle with tx_byte = next response byte, then go to WAIT_DONE.
  - WAIT_DONE: on tx_done, go to RESP if bytes remain, otherwise IDLE.
- Latency: mem_req asserts the cycle after the final frame byte's rx_dv. The first tx_dv asserts 1 cycle after mem_ready, provided tx_active=0.
- Timeout:
  - The counter runs only in ADDR and DATA, and clears on every rx_dv.
  - On reaching TIMEOUT_CYCLES-1: return to IDLE, no response, no bus transaction.
- Busy drop: rx_dv in MEM, RESP or WAIT_DONE discards the byte and sets err_drop. Only reset clears err_drop.
- Simultaneous timeout expiry and rx_dv: the byte wins and the counter clears.
- Reset mid-transaction:
  - mem_req and tx_dv drop immediately (asynchronous).
  - The partially received frame is lost.
  - A uart_tx byte already in flight completes independently.
- Address is unaligned-agnostic: passed through unmodified.

Optional Feature:
- UART_CMD_CHECKSUM_EN defined:
  - Every frame carries one extra trailing byte, the XOR of all preceding frame bytes including the command. Checked in an added CHK state before MEM.
  - Mismatch: no bus transaction; respond NAK 0x15.
  - Match: normal flow.
  - Read responses append a 5th byte, the XOR of D0..D3.
- Undefined: no CHK state, no checksum bytes in either direction.

Decomposition:
- Package uart_cmd_pkg holds:
  - Command codes CMD_WR=8'h57 and CMD_RD=8'h52.
  - RSP_ACK=8'h06 and RSP_NAK=8'h15.
  - FSM state enum typedef.
  - Frame length constants.
- One sub-module: uart_cmd_resp_ser, the response shift register plus byte counter driving the tx_dv/tx_done handshake.

Test Plan:
- Write frame 57 10 00 00 80 EF BE AD DE → single mem_req with mem_we=1, mem_addr=0x80000010, mem_wdata=0xDEADBEEF; after mem_ready, tx_byte=0x06 with one tx_dv pulse.
- Read frame 52 00 01 00 00 with mem_rdata=0x12345678, mem_ready after 3 cycles → mem_we=0, mem_addr=0x00000100; tx bytes 78 56 34 12, each tx_dv only after the previous tx_done.
- Byte 0xAA in IDLE → no mem_req, one tx_byte=0x15; FSM back in IDLE after tx_done.
- 57 plus 3 address bytes, then silence ≥ TIMEOUT_CYCLES (overridden to 50) → return to IDLE, no mem_req, no tx_dv; a following valid read frame works normally.
- rx_dv with 0x52 during WAIT_DONE of a read response → byte ignored, err_drop=1, response stream unaltered.
- resetn low while mem_req=1 → mem_req=0 in the same cycle, all outputs at reset values; with UART_CMD_CHECKSUM_EN, write frame with a wrong checksum byte → no mem_req, tx_byte=0x15.
